// File: rtl/blink_monitor_if.sv
// Read port of the blink_monitor interval buffer: first-word-fall-through, valid/ready.
interface blink_monitor_if;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/blink_monitor.sv
// Measures the interval between toggles of blink, checks it against the expected period and
// queues every measured interval in an 8-entry FWFT buffer.
module blink_monitor #(
  parameter int unsigned EXPECTED_PERIOD = 8,
  parameter int unsigned TIMEOUT         = 16,
  parameter int unsigned LOCK_COUNT      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  blink,
  blink_monitor_if.master       rd,
  output logic                  locked,
  output logic                  err,
  output logic                  overflow,
  output logic [15:0]           toggle_count
);

  localparam int unsigned Depth   = 8;
  localparam int unsigned StreakW = $clog2(LOCK_COUNT + 1);
  localparam logic [StreakW-1:0] LockMax = StreakW'(LOCK_COUNT);

  typedef enum logic [0:0] {StIdle, StMeas} state_e;

  state_e              state_q, state_d;
  logic                blink_q;
  logic [31:0]         cnt_q;
  logic [StreakW-1:0]  streak_q, streak_d;
  logic                locked_q, locked_d;
  logic                err_q, err_d;
  logic                overflow_q;
  logic [15:0]         toggle_count_q;
  logic                toggle;
  logic                push_req;

  logic [31:0]         mem [Depth];
  logic [2:0]          wr_ptr_q, rd_ptr_q;
  logic [3:0]          count_q;
  logic                full, push, pop, drop;

  assign toggle = (blink != blink_q);

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    locked_d = locked_q;
    err_d    = 1'b0;
    push_req = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (toggle) state_d = StMeas;
      end
      StMeas: begin
        if (toggle) begin
          push_req = 1'b1;
          if (cnt_q == EXPECTED_PERIOD) begin
            if (streak_q != LockMax) streak_d = streak_q + 1'b1;
            if (streak_d == LockMax) locked_d = 1'b1;
          end else begin
            streak_d = '0;
            locked_d = 1'b0;
            err_d    = 1'b1;
          end
        end else if (cnt_q == TIMEOUT) begin
          // Stall: the next toggle only re-establishes a reference point.
          err_d    = 1'b1;
          streak_d = '0;
          locked_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign full = (count_q == 4'(Depth));
  assign pop  = (count_q != 4'd0) && rd.rd_ready;
  assign push = push_req && (!full || pop);
  assign drop = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      blink_q        <= 1'b0;
      cnt_q          <= '0;
      streak_q       <= '0;
      locked_q       <= 1'b0;
      err_q          <= 1'b0;
      overflow_q     <= 1'b0;
      toggle_count_q <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
    end else begin
      state_q  <= state_d;
      blink_q  <= blink;
      cnt_q    <= toggle ? 32'd1 : cnt_q + 32'd1;
      streak_q <= streak_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      if (drop)   overflow_q     <= 1'b1;
      if (toggle) toggle_count_q <= toggle_count_q + 16'd1;
      if (push)   wr_ptr_q       <= wr_ptr_q + 3'd1;
      if (pop)    rd_ptr_q       <= rd_ptr_q + 3'd1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 4'd1;
        2'b01:   count_q <= count_q - 4'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= cnt_q;
  end

  assign rd.rd_valid   = (count_q != 4'd0);
  assign rd.rd_data    = mem[rd_ptr_q];
  assign locked        = locked_q;
  assign err           = err_q;
  assign overflow      = overflow_q;
  assign toggle_count  = toggle_count_q;

endmodule
